regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-port controller for the 32x32 register file. It shares the single write port (wn, d, we) between two write-back requesters, A and B, using round-robin priority. It also runs a software-triggered clear sequence that zeroes r1..r31 over 31 cycles. It sits between the datapath write-back sources and the register file write inputs; the read ports (rna/rnb/qa/qb) are untouched.

## Interface
Parameters:
- NREG, 32: number of registers; the clear sequence covers 1..NREG-1.
- AW, 5: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock; the register file writes on the same rising edge.
- clr  in  1  reset, asynchronous, active-high.
- a_req  in  1  requester A has a write pending.
- a_wn  in  AW  A destination register.
- a_d  in  DW  A write data.
- a_gnt  out  1  A write accepted at the next rising edge.
- b_req, b_wn, b_d, b_gnt: same as A, for requester B.
- init  in  1  start the clear sequence; sampled at a rising edge.
- busy  out  1  clear sequence in progress.
- wn  out  AW  to register file write address.
- d  out  DW  to register file write data.
- we  out  1  to register file write enable.

## Operation
- Two states, IDLE and CLEAR, plus state registers prio (0 = A preferred) and cnt[AW-1:0].
- IDLE arbitration is combinational from the req inputs and prio:
  - Only A requests: a_gnt=1.
  - Only B requests: b_gnt=1.
  - Both request: grant goes to A if prio=0, else to B.
  - Neither requests: no grant, we=0.
  - Never both grants high.
- Granted requester drives wn/d; we=1 unless the granted wn==0. A write to r0 is granted (consumed) but suppressed, we=0.
- prio update at each edge with a grant: grant to A sets prio=1; grant to B clears prio=0. No grant leaves prio unchanged.
- Requester protocol:
  - Hold req, wn and d stable until a cycle with gnt=1. The write completes at that cycle's rising edge.
  - The requester may drop req or present a new write the following cycle.
- IDLE to CLEAR: init=1 at an edge while in IDLE; cnt loads 1.
  - A grant issued in that same IDLE cycle still completes.
- CLEAR: we=1, wn=cnt, d=0, a_gnt=b_gnt=0, busy=1.
  - cnt increments each edge.
  - At the edge where cnt==NREG-1, return to IDLE and set cnt=0.
- init while in CLEAR is ignored; the sequence does not restart.
- Requests arriving during CLEAR are held off. They are arbitrated in the first IDLE cycle, and prio is unchanged by CLEAR.
- clr asserted at any time, including mid-CLEAR, forces:
  - state=IDLE, prio=0, cnt=0.
  - The sequence is aborted; registers already zeroed stay zeroed.

## Timing
- Reset values: state=IDLE, prio=0, cnt=0, busy=0.
  - With no requests: we=0, wn=0, d=0, a_gnt=0, b_gnt=0.
- Grant latency: 0 cycles (combinational). Write lands at the rising edge ending the grant cycle.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate A,B,A,B...
- Clear duration: exactly NREG-1 = 31 cycles with we=1. busy is high for those 31 cycles and drops in the cycle after wn=31 is written.
- The only registered state is state, prio and cnt. wn/d/we/gnt are combinational from the inputs and that state.
- busy is decoded from state only; it has no combinational path from init.

## Test plan
- Reset, then a_req=1, a_wn=3, a_d=0x0000000F for 1 cycle -> a_gnt=1, we=1, wn=3, d=0xF; reading r3 returns 0xF.
- a_req and b_req held high 4 cycles with distinct wn (A:5, B:6) -> grant order A,B,A,B; prio toggles each edge.
- b_req=1, b_wn=0, b_d=0xFFFFFFFF -> b_gnt=1, we=0; r0 reads 0.
- Preload r1..r31 with nonzero values, pulse init -> busy=1 for 31 cycles, wn steps 1..31 with d=0, grants 0 throughout; afterwards all registers read 0.
- a_req held high during CLEAR -> a_gnt=0 for all 31 cycles, a_gnt=1 in the first cycle after busy falls; second init mid-CLEAR does not extend the 31 cycles.
- clr pulsed at cnt=10 in CLEAR -> busy=0, cnt=0, prio=0 immediately (asynchronous); r1..r9 are 0, r10..r31 keep their prior values.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin owner of the register file write port,
// shared by write-back requesters A and B, plus a software-triggered
// sequence that zeroes r1..r(NREG-1).
module regfile_wb_arbiter #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          a_req,
    input  logic [AW-1:0] a_wn,
    input  logic [DW-1:0] a_d,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [AW-1:0] b_wn,
    input  logic [DW-1:0] b_d,
    output logic          b_gnt,
    input  logic          init,
    output logic          busy,
    output logic [AW-1:0] wn,
    output logic [DW-1:0] d,
    output logic          we
);

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST_REG = AW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_pick_a;
    logic          w_pick_b;

    // B wins only when A is absent or B holds priority; A gets the rest
    assign w_pick_b = b_req & (~a_req | r_prio);
    assign w_pick_a = a_req & ~w_pick_b;

    // State, priority and clear-counter registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Arbitration, clear sequencing and write-port drive
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        busy        = 1'b0;
        wn          = '0;
        d           = '0;
        we          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_a) begin
                    a_gnt      = 1'b1;
                    wn         = a_wn;
                    d          = a_d;
                    we         = (a_wn != '0);
                    w_prio_nxt = 1'b1;
                end else if (w_pick_b) begin
                    b_gnt      = 1'b1;
                    wn         = b_wn;
                    d          = b_d;
                    we         = (b_wn != '0);
                    w_prio_nxt = 1'b0;
                end
                // A grant issued alongside init still completes this edge
                if (init) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = FIRST_REG;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                we   = 1'b1;
                wn   = r_cnt;
                if (r_cnt == LAST_REG) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + FIRST_REG;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
